reg_skid_buffer: RTL

REG_SKID_BUFFER -- requirements
Module: reg_skid_buffer

---
 rtl/reg_skid_buffer.sv | 104 ++++++++++
 1 files changed

// File: rtl/reg_skid_buffer.sv
// Two-entry skid buffer (main M drives Q, skid S absorbs one word); optional delivered-word counter via SKID_CNT_EN.
// Latency: a word written on edge N is on Q with VALID=1 in cycle N+1; one word per cycle sustained.
// Backpressure: RDY registered, low only when both M and S hold words; EN while RDY=0 is ignored.
module reg_skid_buffer #(
    parameter int P = 32
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         EN,
    input  logic [P-1:0] D,
    output logic         RDY,
    output logic [P-1:0] Q,
    output logic         VALID,
    input  logic         ACK
`ifdef SKID_CNT_EN
    ,
    output logic [15:0]  CNT
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b10
    } state_t;

    state_t         state_q;
    logic [P-1:0]   m_q;
    logic [P-1:0]   s_q;
    logic           rdy_q;
    logic           valid_q;
    logic           wr;
    logic           rd;

    assign wr = EN & rdy_q;
    assign rd = ACK & valid_q;

    // RDY and VALID are registered alongside the state so they never glitch.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_EMPTY;
            m_q     <= '0;
            s_q     <= '0;
            rdy_q   <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (wr) begin
                        m_q     <= D;
                        state_q <= ST_ONE;
                        valid_q <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (wr && rd) begin
                        m_q <= D;
                    end else if (wr) begin
                        s_q     <= D;
                        state_q <= ST_FULL;
                        rdy_q   <= 1'b0;
                    end else if (rd) begin
                        state_q <= ST_EMPTY;
                        valid_q <= 1'b0;
                    end
                end
                ST_FULL: begin
                    if (rd) begin
                        m_q     <= s_q;
                        state_q <= ST_ONE;
                        rdy_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_EMPTY;
                    valid_q <= 1'b0;
                    rdy_q   <= 1'b1;
                end
            endcase
        end
    end

    assign Q     = m_q;
    assign RDY   = rdy_q;
    assign VALID = valid_q;

`ifdef SKID_CNT_EN
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    assign cnt_d = cnt_q + 16'd1;

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= 16'd0;
        end else if (rd) begin
            cnt_q <= cnt_d;
        end
    end

    assign CNT = cnt_q;
`endif

endmodule
